// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// multicycle_control_fsm
//
// Control sequencer for a multi-cycle RV32I core built around one ALU, one
// unified memory and the IR/MDR/ALUOut registers. Each instruction steps
// through fetch, decode, execute, memory and writeback states. Memory
// accesses wait on a ready handshake, and a watchdog bounds how long any
// single access may stall. Illegal opcodes, memory timeouts and ECALL halts
// each park the machine in HALT and raise a sticky flag. A counter tracks
// retired instructions (one per PC update).
//
// Parameters
//   MEM_TIMEOUT  max wait cycles for mem_ready in a memory state (0 = no limit)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk           clock
//   reset_n       asynchronous active-low reset
//   opcode        IR[6:0], looked at only while decoding
//   bcond         branch-condition result from the ALU
//   halt_req      ECALL halt condition, computed outside this block
//   mem_ready     memory completes the current access this cycle
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   iord          memory address select: 0=PC, 1=ALUOut
//   ir_write      IR load enable
//   mdr_write     MDR load enable
//   aluout_write  ALUOut load enable
//   alu_src_a     ALU A select: 0=PC, 1=rs1
//   alu_src_b     ALU B select: 0=rs2, 1=const 4, 2=imm
//   alu_op        ALU operation: 0=add, 1=sub/compare, 2=funct-decoded
//   wb_sel        register writeback source: 0=ALUOut, 1=MDR, 2=live ALU
//   reg_write     register file write enable
//   pc_write      PC write enable
//   pc_source     PC source: 0=live ALU result, 1=ALUOut
//   halted        sticky: ECALL halt taken
//   illegal       sticky: unknown opcode decoded
//   bus_error     sticky: memory access timed out
//   instret       retired-instruction count, wraps
// ============================================================================
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             aluout_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_source,
    output logic             halted,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam bit               TMO_EN    = (MEM_TIMEOUT > 0);
    localparam int               TMO_W     = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IF,
        S_ID,
        S_EX_ALU,
        S_EX_ADDR,
        S_EX_BR,
        S_EX_JALR,
        S_MEM_LD,
        S_MEM_ST,
        S_WB_ALU,
        S_WB_LD,
        S_JUMP,
        S_PC4,
        S_ECALL,
        S_HALT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;
    logic             op_imm;
    logic             op_store;
    logic             in_wait;
    logic             tmo_expired;
    logic             set_illegal;
    logic             set_halted;

    // State register. Reset drops the machine straight back into fetch so an
    // instruction in flight is abandoned the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IF;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Besides the normal sequencing this watches the three
    // states that wait on memory: once the stall count reaches the limit and
    // memory is still not ready, the machine gives up and halts. A ready on
    // that very cycle still completes the access. The stall count restarts
    // from zero whenever one of those states is entered, because any
    // transition (including MEM_ST back to IF) leaves tmo_next at zero.
    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        set_halted  = 1'b0;
        in_wait     = (state == S_IF) || (state == S_MEM_LD) || (state == S_MEM_ST);
        tmo_expired = TMO_EN && in_wait && !mem_ready && (tmo_cnt == TMO_LIMIT);

        case (state)
            S_IF:      if (mem_ready) state_next = S_ID;
            S_ID: begin
                case (opcode)
                    OP_ARITH, OP_ARITH_IMM: state_next = S_EX_ALU;
                    OP_LOAD, OP_STORE:      state_next = S_EX_ADDR;
                    OP_BRANCH:              state_next = S_EX_BR;
                    OP_JAL:                 state_next = S_JUMP;
                    OP_JALR:                state_next = S_EX_JALR;
                    OP_ECALL:               state_next = S_ECALL;
                    default: begin
                        state_next  = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_EX_ALU:  state_next = S_WB_ALU;
            S_WB_ALU:  state_next = S_IF;
            S_EX_ADDR: state_next = op_store ? S_MEM_ST : S_MEM_LD;
            S_MEM_LD:  if (mem_ready) state_next = S_WB_LD;
            S_WB_LD:   state_next = S_IF;
            S_MEM_ST:  if (mem_ready) state_next = S_IF;
            S_EX_BR:   state_next = bcond ? S_IF : S_PC4;
            S_PC4:     state_next = S_IF;
            S_EX_JALR: state_next = S_JUMP;
            S_JUMP:    state_next = S_IF;
            S_ECALL: begin
                if (halt_req) begin
                    state_next = S_HALT;
                    set_halted = 1'b1;
                end else begin
                    state_next = S_IF;
                end
            end
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_IF;
        endcase

        if (tmo_expired) begin
            state_next = S_HALT;
        end

        tmo_next = '0;
        if (TMO_EN && in_wait && !mem_ready && !tmo_expired) begin
            tmo_next = tmo_cnt + TMO_W'(1);
        end
    end

    // Moore output decode. The only input-qualified outputs are the IR/MDR
    // load enables and the PC writes of MEM_ST, EX_BR and ECALL, which must
    // not fire unless the access finished, the branch is taken, or the ECALL
    // does not halt. While reset is held every strobe is forced low so no
    // datapath register or memory location is touched.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        aluout_write = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = 2'd0;
        wb_sel       = 2'd0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        pc_source    = 1'b0;

        case (state)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_ID: begin
                alu_src_b    = 2'd2;
                aluout_write = 1'b1;
            end
            S_EX_ALU: begin
                alu_src_a    = 1'b1;
                alu_src_b    = op_imm ? 2'd2 : 2'd0;
                alu_op       = 2'd2;
                aluout_write = 1'b1;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
            end
            S_EX_ADDR, S_EX_JALR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd2;
                aluout_write = 1'b1;
            end
            S_MEM_LD: begin
                mem_read  = 1'b1;
                iord      = 1'b1;
                mdr_write = mem_ready;
            end
            S_WB_LD: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
            end
            S_MEM_ST: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                alu_src_b = 2'd1;
                pc_write  = mem_ready;
            end
            S_EX_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_source = 1'b1;
                pc_write  = bcond;
            end
            S_PC4: begin
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
            end
            S_JUMP: begin
                alu_src_b = 2'd1;
                wb_sel    = 2'd2;
                reg_write = 1'b1;
                pc_source = 1'b1;
                pc_write  = 1'b1;
            end
            S_ECALL: begin
                alu_src_b = 2'd1;
                pc_write  = !halt_req;
            end
            default: begin
            end
        endcase

        if (!reset_n) begin
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            iord         = 1'b0;
            ir_write     = 1'b0;
            mdr_write    = 1'b0;
            aluout_write = 1'b0;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'd0;
            alu_op       = 2'd0;
            wb_sel       = 2'd0;
            reg_write    = 1'b0;
            pc_write     = 1'b0;
            pc_source    = 1'b0;
        end
    end

    // Side registers: stall counter, the opcode class remembered from decode
    // (EX_ALU and EX_ADDR need it after the opcode is no longer looked at),
    // the sticky status flags, and the retired-instruction counter, which
    // counts every cycle that updates the PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            op_imm    <= 1'b0;
            op_store  <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
            instret   <= '0;
        end else begin
            tmo_cnt <= tmo_next;
            if (state == S_ID) begin
                op_imm   <= (opcode == OP_ARITH_IMM);
                op_store <= (opcode == OP_STORE);
            end
            if (set_halted) begin
                halted <= 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (tmo_expired) begin
                bus_error <= 1'b1;
            end
            if (pc_write) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// tb_multicycle_control_fsm
//
// Self-checking bench for multicycle_control_fsm. Expected control vectors
// are built per instruction from the cycle-by-cycle behaviour each
// instruction class should show. The expected retire count is simply the
// number of non-halting instructions issued, modulo 2^CNT_W. Inputs that
// a state should ignore (opcode outside decode, bcond, halt_req, and
// mem_ready where no access is pending) are randomised to expose any
// dependence on them.
// ============================================================================
module tb_multicycle_control_fsm;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam int K_ARITH   = 0;
    localparam int K_ARITHI  = 1;
    localparam int K_LOAD    = 2;
    localparam int K_STORE   = 3;
    localparam int K_BR      = 4;
    localparam int K_JAL     = 5;
    localparam int K_JALR    = 6;
    localparam int K_ECALL   = 7;
    localparam int K_ILLEGAL = 8;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       aluout_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       pc_write;
        logic       pc_source;
    } ctl_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [6:0]       opcode = 7'd0;
    logic             bcond = 1'b0;
    logic             halt_req = 1'b0;
    logic             mem_ready = 1'b1;
    logic             mem_read, mem_write, iord, ir_write, mdr_write, aluout_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b, alu_op, wb_sel;
    logic             reg_write, pc_write, pc_source;
    logic             halted, illegal, bus_error;
    logic [CNT_W-1:0] instret;

    ctl_t obs_now;
    assign obs_now = {mem_read, mem_write, iord, ir_write, mdr_write, aluout_write,
                      alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, pc_write, pc_source};

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .bcond       (bcond),
        .halt_req    (halt_req),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .mdr_write   (mdr_write),
        .aluout_write(aluout_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .reg_write   (reg_write),
        .pc_write    (pc_write),
        .pc_source   (pc_source),
        .halted      (halted),
        .illegal     (illegal),
        .bus_error   (bus_error),
        .instret     (instret)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_instret  = 0;

    ctl_t       exp_q[$];
    ctl_t       obs_q[$];
    logic       mr_q[$];
    logic       bc_q[$];
    logic       hr_q[$];
    logic [6:0] op_q[$];

    // Random don't-care values for inputs a state must ignore.
    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    // Expected control vectors, one per kind of cycle an instruction goes
    // through.
    function automatic ctl_t e_zero();
        ctl_t c;
        c = '0;
        return c;
    endfunction

    function automatic ctl_t e_pc4();
        ctl_t c;
        c = '0;
        c.alu_src_b = 2'd1;
        c.pc_write  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_fetch(input logic mr);
        ctl_t c;
        c = '0;
        c.mem_read = 1'b1;
        c.ir_write = mr;
        return c;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t c;
        c = '0;
        c.alu_src_b    = 2'd2;
        c.aluout_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_exalu(input logic imm);
        ctl_t c;
        c = '0;
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = imm ? 2'd2 : 2'd0;
        c.alu_op       = 2'd2;
        c.aluout_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_rs1_imm();
        ctl_t c;
        c = '0;
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = 2'd2;
        c.aluout_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_wb(input logic [1:0] sel);
        ctl_t c;
        c = e_pc4();
        c.reg_write = 1'b1;
        c.wb_sel    = sel;
        return c;
    endfunction

    function automatic ctl_t e_memld(input logic mr);
        ctl_t c;
        c = '0;
        c.mem_read  = 1'b1;
        c.iord      = 1'b1;
        c.mdr_write = mr;
        return c;
    endfunction

    function automatic ctl_t e_memst(input logic mr);
        ctl_t c;
        c = e_pc4();
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.pc_write  = mr;
        return c;
    endfunction

    function automatic ctl_t e_exbr(input logic bc);
        ctl_t c;
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd1;
        c.pc_source = 1'b1;
        c.pc_write  = bc;
        return c;
    endfunction

    function automatic ctl_t e_jump();
        ctl_t c;
        c = e_pc4();
        c.wb_sel    = 2'd2;
        c.reg_write = 1'b1;
        c.pc_source = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_ecall(input logic hr);
        ctl_t c;
        c = e_pc4();
        c.pc_write = !hr;
        return c;
    endfunction

    function automatic logic [6:0] op_of(input int kind);
        case (kind)
            K_ARITH:  return OP_ARITH;
            K_ARITHI: return OP_ARITH_IMM;
            K_LOAD:   return OP_LOAD;
            K_STORE:  return OP_STORE;
            K_BR:     return OP_BRANCH;
            K_JAL:    return OP_JAL;
            K_JALR:   return OP_JALR;
            K_ECALL:  return OP_ECALL;
            default:  return 7'b1111111;
        endcase
    endfunction

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        mr_q.delete();
        bc_q.delete();
        hr_q.delete();
        op_q.delete();
    endtask

    task automatic push(input ctl_t e, input logic mr, input logic bc, input logic hr,
                        input logic [6:0] op);
        exp_q.push_back(e);
        mr_q.push_back(mr);
        bc_q.push_back(bc);
        hr_q.push_back(hr);
        op_q.push_back(op);
    endtask

    // Queue up the full expected cycle sequence of one instruction.
    task automatic add_instr(input int kind, input int if_wait, input int mem_wait,
                             input logic bc, input logic hr);
        for (int w = 0; w < if_wait; w++) push(e_fetch(1'b0), 1'b0, rb(), rb(), ro());
        push(e_fetch(1'b1), 1'b1, rb(), rb(), ro());
        push(e_decode(), rb(), rb(), rb(), op_of(kind));
        case (kind)
            K_ARITH, K_ARITHI: begin
                push(e_exalu(kind == K_ARITHI), rb(), rb(), rb(), ro());
                push(e_wb(2'd0), rb(), rb(), rb(), ro());
            end
            K_LOAD: begin
                push(e_rs1_imm(), rb(), rb(), rb(), ro());
                for (int w = 0; w < mem_wait; w++) push(e_memld(1'b0), 1'b0, rb(), rb(), ro());
                push(e_memld(1'b1), 1'b1, rb(), rb(), ro());
                push(e_wb(2'd1), rb(), rb(), rb(), ro());
            end
            K_STORE: begin
                push(e_rs1_imm(), rb(), rb(), rb(), ro());
                for (int w = 0; w < mem_wait; w++) push(e_memst(1'b0), 1'b0, rb(), rb(), ro());
                push(e_memst(1'b1), 1'b1, rb(), rb(), ro());
            end
            K_BR: begin
                push(e_exbr(bc), rb(), bc, rb(), ro());
                if (!bc) push(e_pc4(), rb(), rb(), rb(), ro());
            end
            K_JAL: begin
                push(e_jump(), rb(), rb(), rb(), ro());
            end
            K_JALR: begin
                push(e_rs1_imm(), rb(), rb(), rb(), ro());
                push(e_jump(), rb(), rb(), rb(), ro());
            end
            K_ECALL: begin
                push(e_ecall(hr), rb(), rb(), hr, ro());
                if (hr) push(e_zero(), rb(), rb(), rb(), ro());
            end
            default: begin
                push(e_zero(), rb(), rb(), rb(), ro());
            end
        endcase
    endtask

    // Drive the queued inputs one cycle at a time and record the outputs.
    // Starts and ends just after a rising edge; samples mid-cycle.
    task automatic play();
        obs_q.delete();
        foreach (exp_q[i]) begin
            mem_ready = mr_q[i];
            bcond     = bc_q[i];
            halt_req  = hr_q[i];
            opcode    = op_q[i];
            #2;
            obs_q.push_back(obs_now);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        exp_instret = 0;
    endtask

    task automatic test_reset();
        #1;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        tests_run++;
        if (obs_now !== e_zero()) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes: got %h want %h", obs_now, e_zero());
        end
        tests_run++;
        if ({halted, illegal, bus_error, instret} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: flags=%b instret=%0d want 0", {halted, illegal, bus_error}, instret);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        exp_instret = 0;
        #1;
        tests_run++;
        if (obs_now !== e_fetch(1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_if: got %h want %h", obs_now, e_fetch(1'b1));
        end
    endtask

    task automatic test_add();
        clear_q();
        add_instr(K_ARITH, 0, 0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL add cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_instret++;
        tests_run++;
        if (instret !== CNT_W'(exp_instret)) begin
            tests_failed++;
            $display("[TB] FAIL add_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_load_wait();
        int pulses;
        clear_q();
        add_instr(K_LOAD, 0, 3, 1'b0, 1'b0);
        add_instr(K_STORE, 0, 2, 1'b0, 1'b0);
        play();
        pulses = 0;
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL load_store cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
            if (i < 8 && obs_q[i].mdr_write) pulses++;
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("[TB] FAIL load_mdr_pulses: got %0d want 1", pulses);
        end
        exp_instret += 2;
        tests_run++;
        if (instret !== CNT_W'(exp_instret)) begin
            tests_failed++;
            $display("[TB] FAIL load_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        clear_q();
        add_instr(K_BR, 0, 0, 1'b1, 1'b0);
        add_instr(K_BR, 0, 0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL branch cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_instret += 2;
        tests_run++;
        if (instret !== CNT_W'(exp_instret)) begin
            tests_failed++;
            $display("[TB] FAIL branch_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_jumps();
        clear_q();
        add_instr(K_JALR, 0, 0, 1'b0, 1'b0);
        add_instr(K_JAL, 1, 0, 1'b0, 1'b0);
        add_instr(K_ECALL, 0, 0, 1'b0, 1'b0);
        add_instr(K_ARITHI, 2, 0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL jumps cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_instret += 4;
        tests_run++;
        if (instret !== CNT_W'(exp_instret)) begin
            tests_failed++;
            $display("[TB] FAIL jumps_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        add_instr(K_ARITH, 0, 0, 1'b0, 1'b0);
        push(e_fetch(1'b1), 1'b1, 1'b0, 1'b0, ro());
        push(e_decode(), 1'b1, 1'b0, 1'b0, OP_ARITH);
        play();
        mem_ready = 1'b1;
        bcond     = 1'b1;
        reset_n   = 1'b0;
        #1;
        tests_run++;
        if (obs_now !== e_zero() || {halted, illegal, bus_error, instret} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_outputs: ctl=%h instret=%0d flags=%b want all 0",
                     obs_now, instret, {halted, illegal, bus_error});
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs_now !== e_zero()) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_held: got %h want 0", obs_now);
        end
        reset_n     = 1'b1;
        exp_instret = 0;
        clear_q();
        add_instr(K_ARITH, 0, 0, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_after cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        clear_q();
        for (int w = 0; w < MEM_TIMEOUT + 1; w++) push(e_fetch(1'b0), 1'b0, rb(), rb(), ro());
        push(e_zero(), 1'b1, rb(), rb(), ro());
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL timeout cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if ({halted, illegal, bus_error} !== 3'b001 || instret !== '0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_flags: flags=%b instret=%0d want 001/0", {halted, illegal, bus_error}, instret);
        end
        apply_reset();
        clear_q();
        add_instr(K_LOAD, MEM_TIMEOUT, MEM_TIMEOUT, 1'b0, 1'b0);
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL timeout_edge cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if ({halted, illegal, bus_error} !== 3'b000 || instret !== CNT_W'(1)) begin
            tests_failed++;
            $display("[TB] FAIL timeout_edge_flags: flags=%b instret=%0d want 000/1", {halted, illegal, bus_error}, instret);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        clear_q();
        add_instr(K_ILLEGAL, 0, 0, 1'b0, 1'b0);
        push(e_zero(), 1'b1, rb(), rb(), ro());
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL illegal cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if ({halted, illegal, bus_error} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL illegal_flags: got %b want 010", {halted, illegal, bus_error});
        end
    endtask

    task automatic test_ecall_halt();
        apply_reset();
        clear_q();
        add_instr(K_ARITH, 0, 0, 1'b0, 1'b0);
        add_instr(K_ECALL, 0, 0, 1'b0, 1'b1);
        push(e_zero(), 1'b1, rb(), rb(), ro());
        play();
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL ecall_halt cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_instret = 1;
        tests_run++;
        if ({halted, illegal, bus_error} !== 3'b100 || instret !== CNT_W'(exp_instret)) begin
            tests_failed++;
            $display("[TB] FAIL ecall_halt_state: flags=%b instret=%0d want 100/%0d",
                     {halted, illegal, bus_error}, instret, exp_instret);
        end
    endtask

    task automatic test_random();
        int kind;
        int if_wait;
        int mem_wait;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            kind     = int'($urandom_range(0, 7));
            if_wait  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, MEM_TIMEOUT));
            mem_wait = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, MEM_TIMEOUT));
            clear_q();
            add_instr(kind, if_wait, mem_wait, rb(), 1'b0);
            play();
            foreach (exp_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL random instr %0d kind %0d cycle %0d: got %h want %h",
                             n, kind, i, obs_q[i], exp_q[i]);
                end
            end
            exp_instret++;
            tests_run++;
            if (instret !== CNT_W'(exp_instret)) begin
                tests_failed++;
                $display("[TB] FAIL random_instret instr %0d: got %0d want %0d",
                         n, instret, exp_instret % (1 << CNT_W));
            end
        end
        tests_run++;
        if ({halted, illegal, bus_error} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL random_flags: got %b want 000", {halted, illegal, bus_error});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jumps();
        test_reset_mid();
        test_timeout();
        test_illegal();
        test_ecall_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
